kuznechik_arbiter: RTL and testbench
====================================

// Module: kuznechik_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares one kuznechik_cipher core among N_REQ requesters.
//  - Accepts 128-bit blocks via per-requester valid/ready.
//  - Drives the core request/ack handshake and returns each result to its owner.
//  - Sits between bus-side register front-ends and the single cipher instance.
// PARAMETERS
//  N_REQ          4     number of requesters (2..8)
//  TIMEOUT_CYCLES 1024  watchdog limit in cycles; used only with KUZ_ARB_TIMEOUT_EN
// PORTS
//  clk_i          in   1          clock
//  rst_i          in   1          synchronous reset, active-high
//  req_valid_i    in   N_REQ      requester i holds a block; held until ready
//  req_data_i     in   N_REQ*128  block of requester i at bits [i*128 +: 128]
//  req_ready_o    out  N_REQ      one-hot pulse: block of requester i accepted this cycle
//  rsp_valid_o    out  N_REQ      one-hot: result for requester i on rsp_data_o
//  rsp_data_o     out  128        ciphertext, stable while any rsp_valid_o bit is high
//  rsp_err_o      out  1          result invalid (timeout); qualifies rsp_valid_o
//  rsp_ack_i      in   N_REQ      owner accepts the result
//  core_request_o out  1          to core request_i
//  core_ack_o     out  1          to core ack_i
//  core_data_o    out  128        to core data_i
//  core_busy_i    in   1          from core busy_o
//  core_valid_i   in   1          from core valid_o
//  core_data_i    in   128        from core data_o
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; ptr=0; state=IDLE.
//  - FSM states: IDLE, ISSUE, WAIT, ACK, RESP, DRAIN.
//  - IDLE:
//    - core_valid_i=1 (stale result after reset) -> DRAIN. Drain has priority over grants.
//    - Else if |req_valid_i and !core_busy_i: winner = first set bit scanning from ptr upward,
//      wrapping modulo N_REQ. Latch owner and data, pulse req_ready_o[owner] for 1 cycle,
//      set ptr = (owner+1) mod N_REQ, go to ISSUE.
//    - Otherwise stay in IDLE.
//  - ISSUE: core_request_o=1 and core_data_o=latched data for exactly 1 cycle -> WAIT.
//  - WAIT: on core_valid_i=1, capture core_data_i into rsp_data_o -> ACK.
//  - ACK: core_ack_o=1 for 1 cycle; rsp_valid_o[owner] asserted the next cycle -> RESP.
//  - RESP: hold rsp_valid_o[owner] and rsp_data_o until rsp_ack_i[owner]=1.
//    - The same cycle, clear rsp_valid_o and go to IDLE.
//    - A new grant is possible at the earliest one cycle later.
//    - rsp_ack_i bits of non-owners are ignored.
//  - DRAIN: core_ack_o=1 for 1 cycle, no response issued -> IDLE.
//  - Latency, no contention, core latency Lc (request to valid):
//    req_ready pulse at t, core_request at t+1, rsp_valid at t+Lc+3.
//  - Fairness: the requester granted last has lowest priority next.
//    With all N_REQ requesting, grant order is ptr, ptr+1, ...
//  - req_valid_i dropped before ready: no grant for that requester; no state change.
//  - Only one block is in flight; core_request_o never asserts while core_busy_i=1.
//  - rst_i in any state: return to IDLE in the next cycle, clear all outputs and drop the in-flight block.
//    A core result arriving later is consumed via DRAIN.
// CONFIGURATION
//  KUZ_ARB_TIMEOUT_EN defined:
//   - A cycle counter runs in WAIT. When it reaches TIMEOUT_CYCLES without core_valid_i:
//     - rsp_data_o=0 and rsp_err_o=1;
//     - go directly to RESP (rsp_valid_o[owner]=1), skipping ACK.
//   - A late core_valid_i is consumed via DRAIN.
//   - rsp_err_o clears with rsp_valid_o.
//  KUZ_ARB_TIMEOUT_EN undefined:
//   - No counter; WAIT is unbounded; rsp_err_o tied to 0.
// TESTING (core model with configurable latency Lc unless noted)
//  1. Real core, requester 0, data 1122334455667700ffeeddccbbaa9988 ->
//     rsp_valid_o=0001, rsp_data_o=7f679d90bebc24305a468d42b9d4edcd, 1 core_ack_o pulse.
//  2. All 4 requesters valid from reset, model echoes ~data, Lc=5 ->
//     grants 0,1,2,3,0; each result goes to the correct owner; rsp_valid_o at ready+8.
//  3. Owner holds off rsp_ack_i for 20 cycles while others request ->
//     rsp_data_o stable, no req_ready_o pulse and no core_request_o until ack.
//  4. rst_i pulse in WAIT, model then asserts core_valid_i ->
//     no rsp_valid_o, single core_ack_o pulse (DRAIN), next request served normally.
//  5. core_busy_i=1 in IDLE with req_valid_i=0010 ->
//     no req_ready_o until busy drops; ready pulses the cycle after busy=0.
//  6. KUZ_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never responds ->
//     rsp_valid_o[owner]=1 with rsp_err_o=1 and rsp_data_o=0, 16 cycles after entering WAIT.

Source files
------------

// File: rtl/kuznechik_arbiter_if.sv
// kuznechik_arbiter_if
//   Requester-side bus of the kuznechik arbiter. Signal suffixes are named
//   from the arbiter's point of view.
//   slave  modport : arbiter side
//   master modport : requester front-ends / testbench side
//   req_valid_i  N_REQ      requester i holds a block
//   req_data_i   N_REQ*128  block of requester i at [i*128 +: 128]
//   req_ready_o  N_REQ      one-hot accept pulse
//   rsp_valid_o  N_REQ      one-hot result valid
//   rsp_data_o   128        result block
//   rsp_err_o    1          result invalid (watchdog timeout)
//   rsp_ack_i    N_REQ      owner accepts the result
interface kuznechik_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ*128-1:0] req_data_i;
  logic [N_REQ-1:0]     req_ready_o;
  logic [N_REQ-1:0]     rsp_valid_o;
  logic [127:0]         rsp_data_o;
  logic                 rsp_err_o;
  logic [N_REQ-1:0]     rsp_ack_i;

  modport slave (
    input  req_valid_i, req_data_i, rsp_ack_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_data_i, rsp_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/kuznechik_arbiter.sv
// kuznechik_arbiter
//   Round-robin arbiter/sequencer sharing one kuznechik cipher core among
//   N_REQ requesters. One block in flight at a time; each result is returned
//   to the requester that supplied it. All outputs are registered.
//
//   Optional feature macro: KUZ_ARB_TIMEOUT_EN
//     defined   : watchdog of TIMEOUT_CYCLES in WAIT, returns an error response
//     undefined : WAIT is unbounded, rsp_err_o is tied low
//
// Ports
//   clk_i           clock
//   rst_i           synchronous reset, active-high
//   req_if          requester bus (kuznechik_arbiter_if.slave)
//   core_request_o  to core request_i
//   core_ack_o      to core ack_i
//   core_data_o     to core data_i
//   core_busy_i     from core busy_o
//   core_valid_i    from core valid_o
//   core_data_i     from core data_o
//
// States
//   state | meaning
//   IDLE  | waiting for a requester, or a stale core result to drain
//   ISSUE | block accepted, core request is raised on the way out
//   WAIT  | core computing, waiting for core_valid_i
//   ACK   | core_ack_o high, result captured
//   RESP  | result presented to owner until its rsp_ack_i
//   DRAIN | acknowledging a core result nobody is waiting for
module kuznechik_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  kuznechik_arbiter_if.slave req_if,
  output logic         core_request_o,
  output logic         core_ack_o,
  output logic [127:0] core_data_o,
  input  logic         core_busy_i,
  input  logic         core_valid_i,
  input  logic [127:0] core_data_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("kuznechik_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    owner_q;
  logic [127:0]     data_q;
  logic [N_REQ-1:0] req_ready_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [127:0]     rsp_data_q;
  logic             core_request_q;
  logic             core_ack_q;
  logic [127:0]     core_data_q;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    ptr_d;

  // First requesting index at or above ptr_q, wrapping modulo N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && req_if.req_valid_i[(int'(ptr_q) + k) % N_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef KUZ_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
  logic          rsp_err_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      owner_q        <= '0;
      data_q         <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      rsp_data_q     <= '0;
      core_request_q <= 1'b0;
      core_ack_q     <= 1'b0;
      core_data_q    <= '0;
`ifdef KUZ_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      core_ack_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A leftover core result must be acknowledged before the core
          // can accept new work, so draining wins over granting.
          if (core_valid_i) begin
            core_ack_q <= 1'b1;
            state_q    <= S_DRAIN;
          end else if (win_found && !core_busy_i) begin
            owner_q     <= win_idx;
            data_q      <= req_if.req_data_i[int'(win_idx)*128 +: 128];
            req_ready_q <= N_REQ'(1) << win_idx;
            ptr_q       <= ptr_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!core_busy_i) begin
            core_request_q <= 1'b1;
            core_data_q    <= data_q;
            state_q        <= S_WAIT;
`ifdef KUZ_ARB_TIMEOUT_EN
            cnt_q          <= CW'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        S_WAIT: begin
          core_request_q <= 1'b0;
          core_data_q    <= '0;
          if (core_valid_i) begin
            rsp_data_q <= core_data_i;
            core_ack_q <= 1'b1;
            state_q    <= S_ACK;
          end
`ifdef KUZ_ARB_TIMEOUT_EN
          else if (cnt_q == '0) begin
            // Error response goes straight out; the core result, if it
            // ever arrives, is drained from IDLE.
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= N_REQ'(1) << owner_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
`endif
        end
        S_ACK: begin
          rsp_valid_q <= N_REQ'(1) << owner_q;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (req_if.rsp_ack_i[owner_q]) begin
            rsp_valid_q <= '0;
`ifdef KUZ_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= S_IDLE;
          end
        end
        S_DRAIN: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_if.req_ready_o = req_ready_q;
  assign req_if.rsp_valid_o = rsp_valid_q;
  assign req_if.rsp_data_o  = rsp_data_q;
`ifdef KUZ_ARB_TIMEOUT_EN
  assign req_if.rsp_err_o   = rsp_err_q;
`else
  assign req_if.rsp_err_o   = 1'b0;
`endif
  assign core_request_o = core_request_q;
  assign core_ack_o     = core_ack_q;
  assign core_data_o    = core_data_q;

endmodule

// File: tb/tb_kuznechik_arbiter.sv
// tb_kuznechik_arbiter
//   Directed bench for kuznechik_arbiter with a behavioural core that returns
//   ~data after a programmable latency Lc (request cycle to valid cycle).
module tb_kuznechik_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         core_request, core_ack, core_busy, core_valid;
  logic [127:0] core_data_to, core_data_from;

  kuznechik_arbiter_if #(.N_REQ(4)) tb_if ();

  kuznechik_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_if         (tb_if),
    .core_request_o (core_request),
    .core_ack_o     (core_ack),
    .core_data_o    (core_data_to),
    .core_busy_i    (core_busy),
    .core_valid_i   (core_valid),
    .core_data_i    (core_data_from)
  );

  always #5 clk = ~clk;

  // Behavioural core model
  int           lc = 5;
  logic         m_respond = 1'b1;
  logic         m_busy = 1'b0;
  logic         m_valid = 1'b0;
  int           m_cnt = 0;
  logic [127:0] m_data = '0;
  logic         tb_busy = 1'b0;

  always @(posedge clk) begin
    if (core_ack) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end else if (core_request) begin
      m_busy <= 1'b1;
      m_cnt  <= lc - 1;
      m_data <= ~core_data_to;
      if (lc == 1) m_valid <= 1'b1;
    end else if (m_busy && !m_valid && m_respond) begin
      if (m_cnt <= 1) m_valid <= 1'b1;
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_busy      = m_busy | tb_busy;
  assign core_valid     = m_valid;
  assign core_data_from = m_data;

  logic [127:0] dtab [4];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [3:0] onehot(input int i);
    return 4'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input int exp);
    int n = 0;
    while (tb_if.req_ready_o == 4'b0 && n < 100) begin
      tick();
      n++;
    end
    check("grant_timeout", 128'(n < 100), 128'd1);
    check("grant_owner", 128'(tb_if.req_ready_o), 128'(onehot(exp)));
  endtask

  task automatic wait_rsp(input int owner, input logic [127:0] exp_data,
                          input logic exp_err, input int exp_lat);
    int n = 0;
    while (tb_if.rsp_valid_o == 4'b0 && n < 2000) begin
      tick();
      n++;
    end
    check("rsp_latency", 128'(n), 128'(exp_lat));
    check("rsp_owner", 128'(tb_if.rsp_valid_o), 128'(onehot(owner)));
    check("rsp_data", tb_if.rsp_data_o, exp_data);
    check("rsp_err", 128'(tb_if.rsp_err_o), 128'(exp_err));
  endtask

  task automatic ack_rsp(input int owner);
    tb_if.rsp_ack_i = onehot(owner);
    tick();
    tb_if.rsp_ack_i = 4'b0;
    check("rsp_cleared", 128'(tb_if.rsp_valid_o), 128'd0);
    check("err_cleared", 128'(tb_if.rsp_err_o), 128'd0);
  endtask

  initial begin
    int acks;
    int saw_rsp;
    dtab[0] = 128'h1122334455667700ffeeddccbbaa9988;
    dtab[1] = 128'h0123456789abcdef0011223344556677;
    dtab[2] = 128'hdeadbeefcafef00d0badc0de5a5aa5a5;
    dtab[3] = 128'h00000000000000000000000000000001;
    rst = 1'b1;
    tb_if.req_valid_i = 4'b0;
    tb_if.req_data_i  = {dtab[3], dtab[2], dtab[1], dtab[0]};
    tb_if.rsp_ack_i   = 4'b0;

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", 128'(tb_if.req_ready_o), 128'd0);
    check("rst_rsp_valid", 128'(tb_if.rsp_valid_o), 128'd0);
    check("rst_rsp_data", tb_if.rsp_data_o, 128'd0);
    check("rst_rsp_err", 128'(tb_if.rsp_err_o), 128'd0);
    check("rst_core_req", 128'(core_request), 128'd0);
    check("rst_core_ack", 128'(core_ack), 128'd0);
    check("rst_core_data", core_data_to, 128'd0);

    // All four requesting, round-robin order 0,1,2,3,0
    tb_if.req_valid_i = 4'b1111;
    rst = 1'b0;
    wait_grant(0); wait_rsp(0, ~dtab[0], 1'b0, 8); ack_rsp(0);
    wait_grant(1); wait_rsp(1, ~dtab[1], 1'b0, 8); ack_rsp(1);
    wait_grant(2); wait_rsp(2, ~dtab[2], 1'b0, 8); ack_rsp(2);
    wait_grant(3); wait_rsp(3, ~dtab[3], 1'b0, 8); ack_rsp(3);
    wait_grant(0); wait_rsp(0, ~dtab[0], 1'b0, 8);
    ack_rsp(0);

    // Owner 2 holds off its ack while the others request and ack spuriously
    tb_if.req_valid_i = 4'b0100;
    wait_grant(2);
    tb_if.req_valid_i = 4'b1011;
    wait_rsp(2, ~dtab[2], 1'b0, 8);
    tb_if.rsp_ack_i = 4'b1011;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold_data", tb_if.rsp_data_o, ~dtab[2]);
      check("hold_valid", 128'(tb_if.rsp_valid_o), 128'(4'b0100));
      check("hold_no_ready", 128'(tb_if.req_ready_o), 128'd0);
      check("hold_no_core_req", 128'(core_request), 128'd0);
    end
    ack_rsp(2);
    wait_grant(3);
    tb_if.req_valid_i = 4'b0;
    wait_rsp(3, ~dtab[3], 1'b0, 8);
    ack_rsp(3);

    // Reset while the core is computing; late result is drained
    tb_if.req_valid_i = 4'b0001;
    wait_grant(0);
    tb_if.req_valid_i = 4'b0;
    tick();
    check("issue_core_req", 128'(core_request), 128'd1);
    check("issue_core_data", core_data_to, dtab[0]);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait_rst_core_req", 128'(core_request), 128'd0);
    check("wait_rst_ready", 128'(tb_if.req_ready_o), 128'd0);
    acks = 0;
    saw_rsp = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (core_ack) acks++;
      if (tb_if.rsp_valid_o != 4'b0) saw_rsp++;
    end
    check("drain_ack_count", 128'(acks), 128'd1);
    check("drain_no_rsp", 128'(saw_rsp), 128'd0);
    tb_if.req_valid_i = 4'b0001;
    wait_grant(0);
    tb_if.req_valid_i = 4'b0;
    wait_rsp(0, ~dtab[0], 1'b0, 8);
    ack_rsp(0);

    // Core busy blocks the grant; ready the cycle after busy drops
    tb_busy = 1'b1;
    tb_if.req_valid_i = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("busy_no_ready", 128'(tb_if.req_ready_o), 128'd0);
    end
    tb_busy = 1'b0;
    tick();
    check("busy_release_ready", 128'(tb_if.req_ready_o), 128'(4'b0010));
    tb_if.req_valid_i = 4'b0;
    wait_rsp(1, ~dtab[1], 1'b0, 8);
    ack_rsp(1);

`ifdef KUZ_ARB_TIMEOUT_EN
    // Core never answers: error response 16 cycles after entering WAIT
    m_respond = 1'b0;
    tb_if.req_valid_i = 4'b0100;
    wait_grant(2);
    tb_if.req_valid_i = 4'b0;
    wait_rsp(2, 128'd0, 1'b1, 17);
    ack_rsp(2);
    m_respond = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_ack) acks++;
    end
    check("timeout_drain_ack", 128'(acks), 128'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
